stride_permutation_pp: RTL and testbench
========================================

# stride_permutation_pp

Parametrised, runtime-configurable streaming permutation for the NTT datapath. It accepts frames of N = 2^LOG_N coefficients at INPUT_PER_CYCLE words per cycle. Each frame is reordered by a per-frame mode: identity, stride rotate-left, stride rotate-right, or bit-reversal. It replaces the fixed per-stage stage_k_permutation blocks between butterfly stages. A ping-pong frame buffer lets back-to-back frames stream with no bubbles.

## Interface
- DATA_WIDTH_PER_INPUT, 28, coefficient width in bits
- INPUT_PER_CYCLE, 64, lanes per beat (P); power of two, 2 ≤ P ≤ N/2
- LOG_N, 10, log2 of frame length N; beats per frame C = N/P
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_start  in  1  one-cycle pulse coincident with beat 0 of an input frame
- mode  in  2  sampled with in_start: 0 identity, 1 rotl, 2 rotr, 3 bit-reverse
- stride_log2  in  $clog2(LOG_N)  sampled with in_start; rotation amount k for modes 1/2
- inData  in  [P-1:0][DATA_WIDTH_PER_INPUT-1:0]  lane j of beat b is element b*P+j
- outData  out  [P-1:0][DATA_WIDTH_PER_INPUT-1:0]  lane j of output beat b is element b*P+j
- out_start  out  1  one-cycle pulse with output beat 0
- out_valid  out  1  high for the C output beats of a frame
- frame_err  out  1  one-cycle pulse on an aborted frame or an illegal stride

## Operation
- Element index: LOG_N bits. Output element o takes input element src(o):
  - mode 0: src = o
  - mode 1: src = rotl(o, k)
  - mode 2: src = rotr(o, k)
  - mode 3: src = bitrev(o)
- Two banks, each holding N words plus latched mode/k. The write bank fills while the other bank drains.
- Fill: in_start selects the current write bank and writes beat 0. Beats 1..C-1 are written on the following consecutive cycles; no valid gaps are allowed. After beat C-1 is written, the bank is marked full and the write pointer toggles.
- Drain: a full bank is read beat by beat in order b = 0..C-1. outData lane j = bank[src(b*P+j)]. The bank is freed after beat C-1 is read.
- Illegal stride: stride_log2 ≥ LOG_N with mode 1 or 2. frame_err pulses with in_start, and the frame is processed as identity.
- Abort: if in_start arrives while a fill is incomplete, the partial frame is discarded and frame_err pulses. The new frame starts in the same bank. A drain already in progress is not affected.
- Frames arriving faster than one per C cycles other than by abort are not possible, because in_start mid-fill always aborts.
- rst mid-operation: both banks are marked empty, all counters clear, any drain is terminated, and buffer contents are don't-care.

## Timing
- Reset values: outData all zero, out_start 0, out_valid 0, frame_err 0. Write pointer is bank 0, read state is idle.
- If in_start occurs at cycle t, beats are sampled at t..t+C-1 and the bank is full at the edge ending cycle t+C-1.
- The read of beat 0 occurs in cycle t+C. outData is registered, so beat 0 appears and out_start pulses in cycle t+C+1. Latency is C+1 cycles.
- out_valid is high on cycles t+C+1..t+2C inclusive.
- Back-to-back: in_start at t+C gives output beats contiguous with the previous frame. out_valid stays high and out_start pulses at t+2C+1.
- Simultaneous events:
  - The drain of bank A overlaps the fill of bank B.
  - A fill completing in the same cycle the other bank finishes draining starts the next drain on the following cycle with no bubble.
- frame_err is registered, one cycle after the causing in_start.
- outData holds its last value when out_valid is 0.

## Structure
- Package perm_pkg:
  - perm_mode_e enum (PERM_ID, PERM_ROTL, PERM_ROTR, PERM_BITREV)
  - pure function perm_src(o, mode, k, LOG_N)
  - parameter-derived localparams (C, beat-counter width)
- Sub-module perm_bank, instantiated twice:
  - N×DATA_WIDTH_PER_INPUT register file with a P-wide write port at a beat address
  - latched mode and k
  - P-wide permuted combinational read at a beat address
- The top module owns the fill counter, drain counter, bank full flags, ping-pong pointers, output registers and error logic.

## Test plan
- Test parameters: N=1024, P=64, C=16, inData lane j of beat b = b*P+j.
- Identity: mode 0 frame at t. out_start at t+17, and beat b lane j = b*64+j for all 16 beats.
- Rotl k=1: beat 0 lane 1 = 2, beat 8 lane 0 = 1, beat 15 lane 63 = 1023.
- Bit-reverse: beat 0 lane 1 = 512, beat 1 lane 0 = 8, beat 0 lane 0 = 0.
- Back-to-back frames: rotr k=3 then bit-reverse, in_start at t and t+16. out_valid is continuously high t+17..t+48, out_start pulses at t+17 and t+33, and each frame uses its own mode.
- Abort and illegal stride:
  - in_start again at t+5: frame_err pulses at t+6, and only the second frame emerges, at t+22.
  - mode 1 with stride_log2=12: frame_err pulses and the output equals identity.
- Reset at t+20 during drain: all outputs are 0 from the next cycle, and no further out_valid occurs until a new frame.

Source files
------------

// File: rtl/perm_pkg.sv
// Shared types and index arithmetic for the ping-pong stride permutation.
// perm_src maps an output element index to the input element index it reads.
package perm_pkg;

    typedef enum logic [1:0] {
        PERM_ID     = 2'd0,
        PERM_ROTL   = 2'd1,
        PERM_ROTR   = 2'd2,
        PERM_BITREV = 2'd3
    } perm_mode_e;

    localparam int PERM_DW_DEF    = 28;
    localparam int PERM_P_DEF     = 64;
    localparam int PERM_LOG_N_DEF = 10;

    // Beats per frame for a given frame size and lane count.
    function automatic int perm_beats(input int log_n, input int p);
        return (1 << log_n) / p;
    endfunction

    function automatic logic [31:0] perm_src(input logic [31:0] o, input perm_mode_e mode,
                                             input logic [31:0] k, input int log_n);
        logic [63:0] w_mask;
        logic [63:0] w_dbl;
        logic [31:0] w_rev;
        w_mask = (64'd1 << log_n) - 64'd1;
        // Two copies of the index side by side turn a rotation into a plain shift.
        w_dbl  = ({32'd0, o} & w_mask) | (({32'd0, o} & w_mask) << log_n);
        w_rev  = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < log_n) begin
                w_rev = {w_rev[30:0], o[i]};
            end
        end
        case (mode)
            PERM_ROTL:   return 32'((w_dbl >> (log_n - int'(k))) & w_mask);
            PERM_ROTR:   return 32'((w_dbl >> k) & w_mask);
            PERM_BITREV: return w_rev;
            default:     return o;
        endcase
    endfunction

endpackage

// File: rtl/perm_bank.sv
// One frame buffer: P-wide write at a beat address, P-wide permuted read.
// The frame's mode and rotation amount are latched alongside the data.
module perm_bank
    import perm_pkg::*;
#(
    parameter int DW    = PERM_DW_DEF,
    parameter int P     = PERM_P_DEF,
    parameter int LOG_N = PERM_LOG_N_DEF,
    localparam int LP   = $clog2(P),
    localparam int CW   = $clog2(perm_beats(LOG_N, P)),
    localparam int KW   = $clog2(LOG_N)
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [CW-1:0]        i_wbeat,
    input  logic [P-1:0][DW-1:0] i_wdata,
    input  logic                 i_cfg,
    input  perm_mode_e           i_mode,
    input  logic [KW-1:0]        i_k,
    input  logic [CW-1:0]        i_rbeat,
    output logic [P-1:0][DW-1:0] o_rdata
);

    logic [DW-1:0]    r_mem [1 << LOG_N];
    perm_mode_e       r_mode;
    logic [KW-1:0]    r_k;
    logic [LOG_N-1:0] w_src [P];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int j = 0; j < P; j++) begin
                r_mem[{i_wbeat, LP'(j)}] <= i_wdata[j];
            end
        end
        if (i_cfg) begin
            r_mode <= i_mode;
            r_k    <= i_k;
        end
    end

    always_comb begin
        for (int j = 0; j < P; j++) begin
            w_src[j]   = LOG_N'(perm_src(32'({i_rbeat, LP'(j)}), r_mode, 32'(r_k), LOG_N));
            o_rdata[j] = r_mem[w_src[j]];
        end
    end

endmodule

// File: rtl/stride_permutation_pp.sv
// Streaming frame permutation with two ping-pong banks: one fills while the
// other drains, so back-to-back frames leave with no bubble, latency C+1.
module stride_permutation_pp
    import perm_pkg::*;
#(
    parameter int DATA_WIDTH_PER_INPUT = PERM_DW_DEF,
    parameter int INPUT_PER_CYCLE      = PERM_P_DEF,
    parameter int LOG_N                = PERM_LOG_N_DEF
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 in_start,
    input  logic [1:0]                                           mode,
    input  logic [$clog2(LOG_N)-1:0]                             stride_log2,
    input  logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0] inData,
    output logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0] outData,
    output logic                                                 out_start,
    output logic                                                 out_valid,
    output logic                                                 frame_err
);

    localparam int C  = perm_beats(LOG_N, INPUT_PER_CYCLE);
    localparam int CW = $clog2(C);

    logic          r_wr_sel;
    logic          r_filling;
    logic [CW-1:0] r_wcnt;
    logic [1:0]    r_full;
    logic          r_rd_sel;
    logic [CW-1:0] r_rcnt;

    logic          w_illegal;
    perm_mode_e    w_mode;
    logic          w_we;
    logic [CW-1:0] w_wbeat;
    logic          w_rd_act;
    logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0] w_rdata [2];

    // An out-of-range rotation is downgraded to identity rather than dropped.
    assign w_illegal = (mode == 2'd1 || mode == 2'd2) && (32'(stride_log2) >= 32'(LOG_N));
    assign w_mode    = w_illegal ? PERM_ID : perm_mode_e'(mode);
    assign w_we      = in_start | r_filling;
    assign w_wbeat   = in_start ? '0 : r_wcnt;
    assign w_rd_act  = r_full[r_rd_sel];

    for (genvar g = 0; g < 2; g++) begin : g_bank
        perm_bank #(
            .DW    (DATA_WIDTH_PER_INPUT),
            .P     (INPUT_PER_CYCLE),
            .LOG_N (LOG_N)
        ) u_bank (
            .clk     (clk),
            .i_we    (w_we && (r_wr_sel == 1'(g))),
            .i_wbeat (w_wbeat),
            .i_wdata (inData),
            .i_cfg   (in_start && (r_wr_sel == 1'(g))),
            .i_mode  (w_mode),
            .i_k     (stride_log2),
            .i_rbeat (r_rcnt),
            .o_rdata (w_rdata[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_sel  <= 1'b0;
            r_filling <= 1'b0;
            r_wcnt    <= '0;
            r_full    <= '0;
            r_rd_sel  <= 1'b0;
            r_rcnt    <= '0;
            outData   <= '0;
            out_start <= 1'b0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= in_start && (r_filling || w_illegal);

            if (w_rd_act) begin
                outData   <= w_rdata[r_rd_sel];
                out_valid <= 1'b1;
                out_start <= (r_rcnt == '0);
                if (r_rcnt == CW'(C - 1)) begin
                    r_full[r_rd_sel] <= 1'b0;
                    r_rd_sel         <= ~r_rd_sel;
                    r_rcnt           <= '0;
                end else begin
                    r_rcnt <= r_rcnt + 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
                out_start <= 1'b0;
            end

            // A start during an unfinished fill restarts the same bank.
            if (in_start) begin
                r_filling <= 1'b1;
                r_wcnt    <= CW'(1);
            end else if (r_filling) begin
                if (r_wcnt == CW'(C - 1)) begin
                    r_filling        <= 1'b0;
                    r_wcnt           <= '0;
                    r_full[r_wr_sel] <= 1'b1;
                    r_wr_sel         <= ~r_wr_sel;
                end else begin
                    r_wcnt <= r_wcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stride_permutation_pp.sv
// Directed bench for stride_permutation_pp: frames are driven cycle by cycle,
// expected beats and event cycles are queued and matched as the DUT emits them.
module tb_stride_permutation_pp;

    localparam int DW    = 28;
    localparam int P     = 64;
    localparam int LOG_N = 10;
    localparam int N     = 1024;
    localparam int C     = 16;
    localparam int KW    = 4;
    localparam int W     = P * DW;

    typedef logic [P-1:0][DW-1:0] beat_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_start;
    logic [1:0]    mode;
    logic [KW-1:0] stride_log2;
    beat_t         inData;
    beat_t         outData;
    logic          out_start;
    logic          out_valid;
    logic          frame_err;

    logic [W:0] exp_q[$];
    int         start_q[$];
    int         err_q[$];

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    valid_cnt = 0;
    int    cur_run   = 0;
    int    max_run   = 0;
    int    cap_idx   = 0;
    beat_t cap [C];
    beat_t last_out = '0;

    stride_permutation_pp #(
        .DATA_WIDTH_PER_INPUT (DW),
        .INPUT_PER_CYCLE      (P),
        .LOG_N                (LOG_N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_start    (in_start),
        .mode        (mode),
        .stride_log2 (stride_log2),
        .inData      (inData),
        .outData     (outData),
        .out_start   (out_start),
        .out_valid   (out_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    function automatic int ref_src(input int o, input int md, input int k);
        int r;
        case (md)
            1: r = ((o << k) | (o >> (LOG_N - k))) & (N - 1);
            2: r = ((o >> k) | (o << (LOG_N - k))) & (N - 1);
            3: begin
                r = 0;
                for (int i = 0; i < LOG_N; i++) begin
                    if (((o >> i) & 1) == 1) r = r | (1 << (LOG_N - 1 - i));
                end
            end
            default: r = o;
        endcase
        return r;
    endfunction

    function automatic beat_t pattern(input int tag, input int b);
        beat_t v;
        for (int j = 0; j < P; j++) v[j] = DW'(tag * N + b * P + j);
        return v;
    endfunction

    function automatic int first_diff(input beat_t a, input beat_t e);
        for (int l = 0; l < P; l++) begin
            if (a[l] !== e[l]) return l;
        end
        return 0;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic check_beat(input beat_t got, input beat_t exp, input logic sgot, input logic sexp);
        int l;
        l = first_diff(got, exp);
        n_tests++;
        assert (got === exp && sgot === sexp) else begin
            n_fail++;
            $error("FAIL beat at cycle %0d lane %0d: got %0d start %0b expected %0d start %0b",
                   cyc, l, got[l], sgot, exp[l], sexp);
        end
    endtask

    task automatic monitor();
        logic [W:0] e;
        int         t;
        if (frame_err) begin
            check("frame_err_expected", 64'(err_q.size() != 0), 64'd1);
            if (err_q.size() != 0) begin
                t = err_q.pop_front();
                check("frame_err_cycle", 64'(cyc), 64'(t));
            end
        end
        if (out_start) begin
            check("out_start_expected", 64'(start_q.size() != 0), 64'd1);
            if (start_q.size() != 0) begin
                t = start_q.pop_front();
                check("out_start_cycle", 64'(cyc), 64'(t));
            end
        end
        if (out_valid) begin
            valid_cnt++;
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
            if (out_start) cap_idx = 0;
            if (cap_idx < C) cap[cap_idx] = outData;
            cap_idx++;
            check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_beat(outData, e[W-1:0], out_start, e[W]);
            end
        end else begin
            cur_run = 0;
            check("idle_out_start", 64'(out_start), 64'd0);
            check("idle_hold", 64'(outData === last_out), 64'd1);
        end
        last_out = outData;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic idle(input int n);
        in_start = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_frame(input int tag, input int md, input int k, input int nbeats, input bit err_exp);
        int    t0;
        int    eff;
        beat_t v;
        t0 = cyc;
        if (err_exp) err_q.push_back(t0 + 1);
        for (int b = 0; b < nbeats; b++) begin
            in_start    = (b == 0);
            mode        = 2'(md);
            stride_log2 = KW'(k);
            inData      = pattern(tag, b);
            tick();
        end
        in_start = 1'b0;
        if (nbeats == C) begin
            eff = ((md == 1 || md == 2) && k >= LOG_N) ? 0 : md;
            for (int b = 0; b < C; b++) begin
                for (int j = 0; j < P; j++) v[j] = DW'(tag * N + ref_src(b * P + j, eff, k));
                exp_q.push_back({(b == 0), v});
            end
            start_q.push_back(t0 + C + 1);
        end
    endtask

    task automatic end_checks(input string name);
        check({name, "_beats_left"}, 64'(exp_q.size()), 64'd0);
        check({name, "_starts_left"}, 64'(start_q.size()), 64'd0);
        check({name, "_errs_left"}, 64'(err_q.size()), 64'd0);
    endtask

    initial begin
        int vc;
        rst = 1'b1;
        in_start = 1'b0;
        mode = 2'd0;
        stride_log2 = '0;
        inData = '0;
        idle(3);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_start", 64'(out_start), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_outData_zero", 64'(outData === '0), 64'd1);
        rst = 1'b0;
        idle(2);

        // Identity
        drive_frame(0, 0, 0, C, 1'b0);
        idle(20);
        check("id_b0_l0", 64'(cap[0][0]), 64'd0);
        check("id_b5_l7", 64'(cap[5][7]), 64'd327);
        check("id_b15_l63", 64'(cap[15][63]), 64'd1023);
        end_checks("identity");

        // Rotate left by 1
        drive_frame(0, 1, 1, C, 1'b0);
        idle(20);
        check("rotl_b0_l1", 64'(cap[0][1]), 64'd2);
        check("rotl_b8_l0", 64'(cap[8][0]), 64'd1);
        check("rotl_b15_l63", 64'(cap[15][63]), 64'd1023);
        end_checks("rotl");

        // Bit reverse
        drive_frame(0, 3, 0, C, 1'b0);
        idle(20);
        check("brev_b0_l1", 64'(cap[0][1]), 64'd512);
        check("brev_b1_l0", 64'(cap[1][0]), 64'd8);
        check("brev_b0_l0", 64'(cap[0][0]), 64'd0);
        end_checks("bitrev");

        // Back-to-back: rotr k=3 then bit reverse
        max_run = 0;
        vc = valid_cnt;
        drive_frame(1, 2, 3, C, 1'b0);
        drive_frame(2, 3, 0, C, 1'b0);
        idle(20);
        check("b2b_run_len", 64'(max_run), 64'd32);
        check("b2b_valid_cnt", 64'(valid_cnt - vc), 64'd32);
        check("b2b_f2_b0_l1", 64'(cap[0][1]), 64'(2 * N + 512));
        end_checks("b2b");

        // Abort after five beats, restart with rotl k=5
        vc = valid_cnt;
        drive_frame(3, 1, 2, 5, 1'b0);
        drive_frame(4, 1, 5, C, 1'b1);
        idle(20);
        check("abort_valid_cnt", 64'(valid_cnt - vc), 64'd16);
        end_checks("abort");

        // Illegal stride falls back to identity
        drive_frame(5, 1, 12, C, 1'b1);
        idle(20);
        check("illegal_b3_l4", 64'(cap[3][4]), 64'(5 * N + 3 * P + 4));
        end_checks("illegal");

        // Reset during drain
        drive_frame(6, 0, 0, C, 1'b0);
        idle(4);
        rst = 1'b1;
        last_out = '0;
        exp_q.delete();
        start_q.delete();
        tick();
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_start", 64'(out_start), 64'd0);
        check("mid_rst_outData_zero", 64'(outData === '0), 64'd1);
        rst = 1'b0;
        vc = valid_cnt;
        idle(25);
        check("post_rst_no_valid", 64'(valid_cnt - vc), 64'd0);
        drive_frame(7, 3, 0, C, 1'b0);
        idle(20);
        check("post_rst_frame_valid", 64'(valid_cnt - vc), 64'd16);
        end_checks("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
